// File: rtl/jtframe_bank_arb.sv
// Per-channel single-entry read cache in front of one SDRAM bank; misses are arbitrated (round-robin or fixed) onto ba_rd/ba_addr.
// Hits return combinationally; a miss is issued one cycle after it appears and the channel holds ch_rd until ch_ok rises.
module jtframe_bank_arb #(
    parameter int CH   = 4,
    parameter int AW   = 22,
    parameter int DW   = 32,
    parameter int PRIO = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [CH*AW-1:0]  ch_addr,
    input  logic [CH-1:0]     ch_rd,
    output logic [CH-1:0]     ch_ok,
    output logic [CH*DW-1:0]  ch_data,
    output logic [AW-1:0]     ba_addr,
    output logic              ba_rd,
    input  logic              ba_ack,
    input  logic              ba_rdy,
    input  logic [DW-1:0]     sdram_dout
);

    localparam int IW = $clog2(CH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, nxt;
    logic [AW-1:0]   caddr [CH];
    logic [DW-1:0]   cdata [CH];
    logic [CH-1:0]   valid, hit, pend;
    logic [IW-1:0]   gnt, last, sel;
    logic            any_pend, done, stale;
    logic [2*CH-1:0] dbl;
    logic [CH-1:0]   rot;
    int              off;

    always_comb begin
        hit     = '0;
        ch_data = '0;
        for (int n = 0; n < CH; n++) begin
            hit[n] = ch_rd[n] & valid[n] & (ch_addr[n*AW +: AW] == caddr[n]);
            ch_data[n*DW +: DW] = cdata[n];
        end
        ch_ok    = hit;
        pend     = ch_rd & ~hit;
        any_pend = |pend;
    end

    // Round-robin rotates the pending vector so bit 0 is the channel after the last grant
    always_comb begin
        sel = '0;
        off = 0;
        dbl = '0;
        rot = '0;
        if (PRIO != 0) begin
            for (int i = CH-1; i >= 0; i--)
                if (pend[i]) sel = IW'(i);
        end else begin
            dbl = {pend, pend} >> (int'(last) + 1);
            rot = dbl[CH-1:0];
            for (int j = CH-1; j >= 0; j--)
                if (rot[j]) off = j;
            sel = IW'((int'(last) + 1 + off) % CH);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (any_pend) nxt = REQ;
            REQ:     if (ba_ack)   nxt = ba_rdy ? IDLE : WAIT;
            WAIT:    if (ba_rdy)   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ba_rd = (state == REQ);
        done  = ((state == REQ) & ba_ack & ba_rdy) | ((state == WAIT) & ba_rdy);
    end

    // stale marks an in-flight read that saw a flush; its data is stored but never marked valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ba_addr <= '0;
            gnt     <= '0;
            last    <= IW'(CH-1);
            stale   <= 1'b0;
            valid   <= '0;
            for (int n = 0; n < CH; n++) begin
                caddr[n] <= '0;
                cdata[n] <= '0;
            end
        end else begin
            if (state == IDLE && any_pend) begin
                ba_addr <= ch_addr[int'(sel)*AW +: AW];
                gnt     <= sel;
                last    <= sel;
                stale   <= 1'b0;
            end else if (flush && state != IDLE) begin
                stale   <= 1'b1;
            end
            if (flush) valid <= '0;
            if (done) begin
                caddr[gnt] <= ba_addr;
                cdata[gnt] <= sdram_dout;
                if (!flush && !stale) valid[gnt] <= 1'b1;
            end
        end
    end

endmodule
